// File: rtl/parking_lot_car_emulator.sv
// parking_lot_car_emulator: drives the two-beam pattern {A,B} of one car passing
// the lot gate (enter: 10,11,01,00 / exit: 01,11,10,00), each phase HOLD_CYCLES long.
// Optional feature macro: PARK_EMU_ABORT_EN adds the abort input / aborted pulse,
// letting a car back out part-way through the gate.
module parking_lot_car_emulator #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       dir,
    output logic [1:0] x,
    output logic       busy,
    output logic       done
`ifdef PARK_EMU_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_end;
`ifdef PARK_EMU_ABORT_EN
    logic             abrt_q, abrt_d;
    logic             aborted_q, aborted_d;
`endif

    // Beam pattern shown while in a given phase; GAP and IDLE leave both beams clear.
    function automatic logic [1:0] phase_pattern(input state_t s, input logic d);
        case (s)
            PH1:     return d ? 2'b10 : 2'b01;
            PH2:     return 2'b11;
            PH3:     return d ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Next-state, phase counter and registered-output computation.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        phase_end = (cnt_q == CNT_LAST);
`ifdef PARK_EMU_ABORT_EN
        abrt_d    = abrt_q;
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PH1;
                    dir_d   = dir;
`ifdef PARK_EMU_ABORT_EN
                    abrt_d  = 1'b0;
`endif
                end
            end
            PH1: begin
`ifdef PARK_EMU_ABORT_EN
                // A car backing out during PH1 has not yet blocked both beams.
                if (abort && !abrt_q) begin
                    state_d = GAP;
                    abrt_d  = 1'b1;
                end else if (phase_end) begin
                    state_d = abrt_q ? GAP : PH2;
                end
`else
                if (phase_end) state_d = PH2;
`endif
            end
            PH2: begin
`ifdef PARK_EMU_ABORT_EN
                if (abort && !abrt_q) begin
                    state_d = PH1;
                    abrt_d  = 1'b1;
                end else if (phase_end) begin
                    state_d = abrt_q ? PH1 : PH3;
                end
`else
                if (phase_end) state_d = PH3;
`endif
            end
            PH3: begin
`ifdef PARK_EMU_ABORT_EN
                if (abort && !abrt_q) begin
                    state_d = PH2;
                    abrt_d  = 1'b1;
                end else if (phase_end) begin
                    state_d = GAP;
                end
`else
                if (phase_end) state_d = GAP;
`endif
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
`ifdef PARK_EMU_ABORT_EN
                    done_d    = !abrt_q;
                    aborted_d = abrt_q;
`else
                    done_d    = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state change and rests at zero in IDLE.
        if (state_d != state_q || state_d == IDLE) cnt_d = '0;
        else                                        cnt_d = cnt_q + CNT_W'(1);

        x_d    = phase_pattern(state_d, dir_d);
        busy_d = (state_d != IDLE);
    end

    // State, counter and output registers; async reset clears beams immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            x_q       <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PARK_EMU_ABORT_EN
            abrt_q    <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            x_q       <= x_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PARK_EMU_ABORT_EN
            abrt_q    <= abrt_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef PARK_EMU_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_parking_lot_car_emulator.sv
// Bench for parking_lot_car_emulator with HOLD_CYCLES = 4.
module tb_parking_lot_car_emulator;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] x;
    logic       busy, done, aborted;

    int passed = 0;
    int total  = 0;

    parking_lot_car_emulator #(.HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .dir     (dir),
        .x       (x),
        .busy    (busy),
        .done    (done)
`ifdef PARK_EMU_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

`ifndef PARK_EMU_ABORT_EN
    assign aborted = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_out(input string nm, input logic [1:0] ex, input logic eb, input logic ed);
        chk({nm, ".x"}, int'(x), int'(ex));
        chk({nm, ".busy"}, int'(busy), int'(eb));
        chk({nm, ".done"}, int'(done), int'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beams for sample number age (1 = first cycle after the accepting edge).
    function automatic logic [1:0] ref_x(input logic d, input int age);
        int ph;
        if (age < 1 || age > 4 * H) return 2'b00;
        ph = (age - 1) / H;
        case (ph)
            0:       return d ? 2'b10 : 2'b01;
            1:       return 2'b11;
            2:       return d ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Occupancy tracker: decodes complete beam sequences into a car count.
    int         occ = 5;
    logic [5:0] seq_code = '0;
    int         seq_n = 0;
    logic [1:0] last_x = 2'b00;
    always @(negedge clk) begin
        if (!reset_n) begin
            seq_code = '0;
            seq_n    = 0;
            last_x   = 2'b00;
        end else if (x != last_x) begin
            if (x == 2'b00) begin
                if (seq_n == 3 && seq_code == 6'b10_11_01) occ++;
                if (seq_n == 3 && seq_code == 6'b01_11_10) occ--;
                seq_code = '0;
                seq_n    = 0;
            end else begin
                seq_code = {seq_code[3:0], x};
                seq_n++;
            end
            last_x = x;
        end
    end

    typedef struct {
        logic       start;
        logic       dir;
        logic [1:0] ex;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl[$];

    initial begin : main
        int   age;
        logic mdir;
        int   done_cnt;
        logic [1:0] pe[4];
        logic [1:0] px[4];
        vec_t v;

        pe[0] = 2'b10; pe[1] = 2'b11; pe[2] = 2'b01; pe[3] = 2'b00;
        px[0] = 2'b01; px[1] = 2'b11; px[2] = 2'b10; px[3] = 2'b00;

        // Exit run then enter run, one row per sampled cycle.
        for (int r = 0; r < 2; r++) begin
            logic d;
            d = (r == 1);
            for (int s = 1; s <= 4 * H + 2; s++) begin
                v.start = (s == 1);
                v.dir   = d;
                v.ex    = (s <= 4 * H) ? (d ? pe[(s - 1) / H] : px[(s - 1) / H]) : 2'b00;
                v.eb    = (s <= 4 * H);
                v.ed    = (s == 4 * H + 1);
                tbl.push_back(v);
            end
        end

        // Reset state, held and after release
        repeat (3) @(negedge clk);
        chk_out("rst_hold", 2'b00, 1'b0, 1'b0);
        chk("rst_hold.aborted", int'(aborted), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk_out("rst_idle", 2'b00, 1'b0, 1'b0);

        // Table-driven exit and enter sequences
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start;
            dir   = tbl[i].dir;
            tick();
            chk_out($sformatf("tbl[%0d]", i), tbl[i].ex, tbl[i].eb, tbl[i].ed);
            chk($sformatf("tbl[%0d].aborted", i), int'(aborted), 0);
            if (i == 17) chk("occ_after_exit", occ, 4);
            if (i == 35) chk("occ_after_enter", occ, 5);
        end
        start = 1'b0;

        // start pulses while busy are ignored; start in the done cycle is accepted
        @(negedge clk);
        start = 1'b1; dir = 1'b1;
        tick();
        done_cnt = 0;
        chk_out("busy_ign.s1", 2'b10, 1'b1, 1'b0);
        for (int s = 2; s <= 4 * H + 1; s++) begin
            start = ((s - 1) == 5 || (s - 1) == 10);
            dir   = 1'b0;
            tick();
            if (done) done_cnt++;
            chk_out($sformatf("busy_ign.s%0d", s), ref_x(1'b1, s), s <= 4 * H, s == 4 * H + 1);
        end
        chk("busy_ign.done_cnt", done_cnt, 1);
        start = 1'b1; dir = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.s1", int'(x), int'(2'b10));
        for (int s = 2; s <= H; s++) begin
            tick();
            chk($sformatf("b2b.s%0d", s), int'(x), int'(2'b10));
        end
        tick();
        chk("b2b.ph2", int'(x), int'(2'b11));

        // Async reset mid-sequence, then a clean run
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b1; dir = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("arst.pre_x", int'(x), int'(2'b11));
        #2 reset_n = 1'b0;
        #1;
        chk("arst.x", int'(x), 0);
        chk("arst.busy", int'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            tick();
            if (done || busy || x != 2'b00) done_cnt++;
        end
        chk("arst.quiet", done_cnt, 0);
        start = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int s = 1; s <= 4 * H + 1; s++) begin
            if (s > 1) tick();
            if (x != ref_x(1'b0, s) || busy != (s <= 4 * H) || done != (s == 4 * H + 1)) done_cnt++;
        end
        chk("arst.rerun_errs", done_cnt, 0);
        chk("arst.rerun_done", int'(done), 1);

`ifdef PARK_EMU_ABORT_EN
        // Car backs out during the both-blocked phase
        begin
            logic [1:0] ab_x[14];
            int occ0;
            occ0 = occ;
            for (int s = 0; s < 14; s++) begin
                if (s < 4)       ab_x[s] = 2'b10;
                else if (s < 6)  ab_x[s] = 2'b11;
                else if (s < 10) ab_x[s] = 2'b10;
                else             ab_x[s] = 2'b00;
            end
            tick();
            start = 1'b1; dir = 1'b1;
            tick();
            start = 1'b0;
            for (int s = 1; s <= 15; s++) begin
                if (s > 1) tick();
                abort = (s == 6);
                if (s <= 14) chk($sformatf("abrt.x%0d", s), int'(x), int'(ab_x[s - 1]));
                chk($sformatf("abrt.busy%0d", s), int'(busy), int'(s <= 14));
                chk($sformatf("abrt.done%0d", s), int'(done), 0);
                chk($sformatf("abrt.aborted%0d", s), int'(aborted), int'(s == 15));
            end
            abort = 1'b0;
            tick();
            chk("abrt.occ", occ, occ0);
        end
`endif

        // Randomised traffic against the cycle-age model, with occasional async reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        age  = -1;
        mdir = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic busy_idle;
            start = ($urandom_range(0, 3) == 0);
            dir   = 1'($urandom_range(0, 1));
            tick();
            busy_idle = (age < 0) || (age >= 4 * H + 1);
            if (busy_idle && start) begin
                age  = 1;
                mdir = dir;
            end else if (age >= 0) begin
                age++;
            end
            chk_out($sformatf("rnd%0d", c), ref_x(mdir, age),
                    (age >= 1 && age <= 4 * H), (age == 4 * H + 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                chk($sformatf("rnd%0d.arst_x", c), int'(x), 0);
                age = -1;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
